// File: rtl/min_max_pkg.sv
// Shared constants and state encodings for the min/max array loader and finder.
// Both blocks import this so they agree on widths and on the Qd bit position.
package min_max_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    // One-hot loader states; the bit positions double as the Qi/Qw/Qs/Qwt decode.
    typedef enum logic [3:0] {
        LD_INI   = 4'b0001,
        LD_WRITE = 4'b0010,
        LD_START = 4'b0100,
        LD_WAIT  = 4'b1000
    } loader_state_e;

    localparam int unsigned LD_QI_BIT  = 0;
    localparam int unsigned LD_QW_BIT  = 1;
    localparam int unsigned LD_QS_BIT  = 2;
    localparam int unsigned LD_QWT_BIT = 3;

    // Finder states; Qd is the done state and drives the loader's Finder_Done.
    typedef enum logic [3:0] {
        FD_INI  = 4'b0001,
        FD_LOAD = 4'b0010,
        FD_COMP = 4'b0100,
        FD_DONE = 4'b1000
    } finder_state_e;

    localparam int unsigned FD_QD_BIT = 3;

endpackage

// File: rtl/min_max_array_loader_if.sv
// Load stream, finder read port and finder handshake of the min/max array loader.
interface min_max_array_loader_if;
    import min_max_pkg::*;

    logic             Load_Req;
    logic [WIDTH-1:0] Din;
    logic             Din_Valid;
    logic             Din_Ready;
    logic [AW-1:0]    Rd_Addr;
    logic [WIDTH-1:0] Rd_Data;
    logic             Start_Out;
    logic             Finder_Done;

    modport master (
        output Load_Req, Din, Din_Valid, Rd_Addr, Finder_Done,
        input  Din_Ready, Rd_Data, Start_Out
    );

    modport slave (
        input  Load_Req, Din, Din_Valid, Rd_Addr, Finder_Done,
        output Din_Ready, Rd_Data, Start_Out
    );

endinterface

// File: rtl/min_max_regfile.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
// Contents are never reset so they survive a loader Reset.
module min_max_regfile
    import min_max_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/min_max_array_loader.sv
// Writer side of the min/max finder: fills the array from a valid/ready stream,
// pulses Start to the finder after the last element, then waits for its done state.
module min_max_array_loader
    import min_max_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset,
    min_max_array_loader_if.slave  bus,
    output logic [AW-1:0]          W,
    output logic                   Qi,
    output logic                   Qw,
    output logic                   Qs,
    output logic                   Qwt
);

    loader_state_e state_q, state_d;
    logic [AW-1:0] w_q, w_d;
    logic          we;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= LD_INI;
        end else begin
            state_q <= state_d;
        end
    end

    // The write index carries no reset; INI clears it on every clock instead.
    always_ff @(posedge Clk) begin
        w_q <= w_d;
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        we      = 1'b0;
        case (state_q)
            LD_INI: begin
                w_d = '0;
                if (bus.Load_Req) begin
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                if (bus.Din_Valid) begin
                    we  = 1'b1;
                    w_d = w_q + AW'(1);
                    if (w_q == AW'(DEPTH - 1)) begin
                        state_d = LD_START;
                    end
                end
            end
            LD_START: begin
                state_d = LD_WAIT;
            end
            LD_WAIT: begin
                if (bus.Finder_Done) begin
                    state_d = LD_INI;
                end
            end
            default: begin
                state_d = LD_INI;
            end
        endcase
    end

    min_max_regfile u_regfile (
        .clk   (Clk),
        .we    (we),
        .waddr (w_q),
        .wdata (bus.Din),
        .raddr (bus.Rd_Addr),
        .rdata (bus.Rd_Data)
    );

    assign Qi  = state_q[LD_QI_BIT];
    assign Qw  = state_q[LD_QW_BIT];
    assign Qs  = state_q[LD_QS_BIT];
    assign Qwt = state_q[LD_QWT_BIT];
    assign W   = w_q;

    assign bus.Din_Ready = Qw;
    assign bus.Start_Out = Qs;

endmodule

// File: tb/tb_min_max_array_loader.sv
// Randomized bench for min_max_array_loader with a phase/beat-count reference model
// and a behavioural finder that scans the array through the read port.
module tb_min_max_array_loader;
    import min_max_pkg::*;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] W;
    logic          Qi, Qw, Qs, Qwt;

    min_max_array_loader_if bus();

    min_max_array_loader dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus),
        .W     (W),
        .Qi    (Qi),
        .Qw    (Qw),
        .Qs    (Qs),
        .Qwt   (Qwt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 loading, 2 start pulse, 3 waiting for finder.
    int               phase = 0;
    logic [AW-1:0]    beats = '0;
    bit               w_known = 1'b0;
    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               ref_ok [DEPTH];

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            phase   <= 0;
            w_known <= 1'b0;
        end else begin
            case (phase)
                0: begin
                    beats   <= '0;
                    w_known <= 1'b1;
                    if (bus.Load_Req) phase <= 1;
                end
                1: if (bus.Din_Valid) begin
                    ref_mem[beats] <= bus.Din;
                    ref_ok[beats]  <= 1'b1;
                    beats          <= beats + 4'd1;
                    if (beats == 4'd15) phase <= 2;
                end
                2: phase <= 3;
                default: if (bus.Finder_Done) phase <= 0;
            endcase
        end
    end

    logic [5:0] obs_flags, exp_flags;
    assign obs_flags = {Qi, Qw, Qs, Qwt, bus.Din_Ready, bus.Start_Out};
    assign exp_flags = {phase == 0, phase == 1, phase == 2, phase == 3, phase == 1, phase == 2};

    typedef struct {
        logic             lr;
        logic             dv;
        logic [WIDTH-1:0] d;
        logic             fd;
        int               gap_w;
    } stim_t;

    task automatic step(input logic lr, input logic dv, input logic [WIDTH-1:0] d, input logic fd);
        bus.Load_Req    = lr;
        bus.Din_Valid   = dv;
        bus.Din         = d;
        bus.Finder_Done = fd;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Drives one complete load; returns in the Start_Out cycle.
    task automatic run_load(input logic [WIDTH-1:0] data [DEPTH], input int gaps [DEPTH],
                            input bit ini_beat, input bit fd_gap,
                            output int start_cycle, output int pulses);
        stim_t            q [$];
        stim_t            s;
        logic [WIDTH-1:0] m0;
        bit               m0_ok;
        m0 = ref_mem[0];
        m0_ok = ref_ok[0];
        start_cycle = -1;
        pulses = 0;
        q.push_back('{1'b1, ini_beat, 8'hAA, 1'b0, -1});
        for (int i = 0; i < DEPTH; i++) begin
            for (int g = 0; g < gaps[i]; g++) q.push_back('{1'b0, 1'b0, WIDTH'($urandom), fd_gap, i});
            q.push_back('{1'b0, 1'b1, data[i], 1'b0, -1});
        end
        for (int k = 0; k < q.size(); k++) begin
            s = q[k];
            step(s.lr, s.dv, s.d, s.fd);
            checks++;
            if (obs_flags !== exp_flags) begin
                failures++;
                $display("FAIL load_flags cyc=%0d got=%b exp=%b", k + 2, obs_flags, exp_flags);
            end
            if (w_known) begin
                checks++;
                if (W !== beats) begin
                    failures++;
                    $display("FAIL load_w cyc=%0d got=%0d exp=%0d", k + 2, W, beats);
                end
            end
            if (s.gap_w >= 0) begin
                checks++;
                if (W !== AW'(s.gap_w)) begin
                    failures++;
                    $display("FAIL gap_w got=%0d exp=%0d", W, s.gap_w);
                end
            end
            if (k == 0 && ini_beat && m0_ok) begin
                bus.Rd_Addr = '0;
                #1;
                checks++;
                if (bus.Rd_Data !== m0) begin
                    failures++;
                    $display("FAIL ini_m0 got=%h exp=%h", bus.Rd_Data, m0);
                end
            end
            if (bus.Start_Out) begin
                pulses++;
                start_cycle = k + 2;
            end
        end
    endtask

    task automatic release_done();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b1);
        checks++;
        if (obs_flags !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b", obs_flags, 6'b100000);
        end
        Reset = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if ({obs_flags, W} !== {6'b100000, 4'd0}) begin
            failures++;
            $display("FAIL post_reset got=%b/%0d exp=100000/0", obs_flags, W);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] data [DEPTH];
        int gaps [DEPTH];
        int sc, np;
        for (int i = 0; i < DEPTH; i++) begin
            data[i] = WIDTH'(8'h10 + i);
            gaps[i] = 0;
        end
        run_load(data, gaps, 1'b0, 1'b0, sc, np);
        checks++;
        if (sc != 18 || np != 1) begin
            failures++;
            $display("FAIL b2b_start got cycle=%0d pulses=%0d exp cycle=18 pulses=1", sc, np);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        bus.Rd_Addr = 4'd5;
        #1;
        checks++;
        if (bus.Rd_Data !== 8'h15) begin
            failures++;
            $display("FAIL b2b_rd5 got=%h exp=15", bus.Rd_Data);
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.Rd_Addr = AW'(a);
            #1;
            checks++;
            if (bus.Rd_Data !== data[a]) begin
                failures++;
                $display("FAIL b2b_mem addr=%0d got=%h exp=%h", a, bus.Rd_Data, data[a]);
            end
        end
        @(negedge Clk);
        step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_gaps();
        logic [WIDTH-1:0] data [DEPTH];
        int gaps [DEPTH];
        int sc, np;
        for (int i = 0; i < DEPTH; i++) begin
            data[i] = WIDTH'($urandom);
            gaps[i] = 0;
        end
        gaps[3] = 4;
        run_load(data, gaps, 1'b0, 1'b1, sc, np);
        checks++;
        if (sc != 22 || np != 1) begin
            failures++;
            $display("FAIL gaps_start got cycle=%0d pulses=%0d exp cycle=22 pulses=1", sc, np);
        end
        bus.Rd_Addr = 4'd3;
        #1;
        checks++;
        if (bus.Rd_Data !== data[3]) begin
            failures++;
            $display("FAIL gaps_m3 got=%h exp=%h", bus.Rd_Data, data[3]);
        end
        @(negedge Clk);
        release_done();
    endtask

    task automatic test_ini_ignore();
        logic [WIDTH-1:0] data [DEPTH];
        int gaps [DEPTH];
        int sc, np;
        for (int i = 0; i < DEPTH; i++) begin
            data[i] = WIDTH'($urandom_range(0, 8'hA9));
            gaps[i] = 0;
        end
        run_load(data, gaps, 1'b1, 1'b0, sc, np);
        bus.Rd_Addr = '0;
        #1;
        checks++;
        if (bus.Rd_Data !== data[0]) begin
            failures++;
            $display("FAIL ini_first_beat got=%h exp=%h", bus.Rd_Data, data[0]);
        end
        @(negedge Clk);
        release_done();
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] data [DEPTH];
        int gaps [DEPTH];
        int sc, np;
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
            checks++;
            if (obs_flags !== exp_flags || bus.Start_Out !== 1'b0) begin
                failures++;
                $display("FAIL partial_flags got=%b exp=%b", obs_flags, exp_flags);
            end
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            data[i] = WIDTH'(8'hFF - i);
            gaps[i] = 0;
        end
        step(1'b0, 1'b0, '0, 1'b0);
        run_load(data, gaps, 1'b0, 1'b0, sc, np);
        checks++;
        if (np != 1) begin
            failures++;
            $display("FAIL reload_pulses got=%0d exp=1", np);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        for (int a = 0; a < DEPTH; a++) begin
            bus.Rd_Addr = AW'(a);
            #1;
            checks++;
            if (bus.Rd_Data !== data[a]) begin
                failures++;
                $display("FAIL reload_mem addr=%0d got=%h exp=%h", a, bus.Rd_Data, data[a]);
            end
        end
        @(negedge Clk);
    endtask

    task automatic test_wait_ignore();
        // Entered while already in the waiting phase from test_reset_mid.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, WIDTH'($urandom), 1'b0);
            checks++;
            if ({Qwt, bus.Din_Ready} !== 2'b10 || obs_flags !== exp_flags) begin
                failures++;
                $display("FAIL wait_hold got=%b exp=%b", obs_flags, exp_flags);
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.Rd_Addr = AW'(a);
            #1;
            checks++;
            if (bus.Rd_Data !== WIDTH'(8'hFF - a)) begin
                failures++;
                $display("FAIL wait_mem addr=%0d got=%h exp=%h", a, bus.Rd_Data, 8'hFF - a);
            end
        end
        @(negedge Clk);
        step(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (obs_flags !== 6'b100000) begin
            failures++;
            $display("FAIL wait_exit got=%b exp=100000", obs_flags);
        end
    endtask

    task automatic test_finder();
        logic [WIDTH-1:0] data [DEPTH];
        logic [WIDTH-1:0] emax, emin, fmax, fmin;
        int gaps [DEPTH];
        int sc, np;
        data[0] = 8'h37; data[1] = 8'h02; data[2] = 8'h90; data[3] = 8'hFE;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 3) data[i] = WIDTH'($urandom_range(3, 253));
            gaps[i] = int'($urandom_range(0, 1));
        end
        emax = data[0];
        emin = data[0];
        foreach (data[i]) begin
            if (data[i] > emax) emax = data[i];
            if (data[i] < emin) emin = data[i];
        end
        run_load(data, gaps, 1'b0, 1'b0, sc, np);
        fmax = 8'h00;
        fmin = 8'hFF;
        for (int a = 0; a < DEPTH; a++) begin
            bus.Rd_Addr = AW'(a);
            #1;
            if (bus.Rd_Data > fmax) fmax = bus.Rd_Data;
            if (bus.Rd_Data < fmin) fmin = bus.Rd_Data;
            step(1'b0, 1'b0, '0, 1'b0);
        end
        checks++;
        if (fmax !== emax || fmin !== emin || emax !== 8'hFE || emin !== 8'h02) begin
            failures++;
            $display("FAIL finder_minmax got max=%h min=%h exp max=fe min=02", fmax, fmin);
        end
        checks++;
        if (Qwt !== 1'b1) begin
            failures++;
            $display("FAIL finder_wait got Qwt=%b exp=1", Qwt);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (obs_flags !== 6'b100000) begin
            failures++;
            $display("FAIL finder_done got=%b exp=100000", obs_flags);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] data [DEPTH];
        int gaps [DEPTH];
        int sc, np, gsum;
        for (int r = 0; r < 4; r++) begin
            gsum = 0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] = WIDTH'($urandom);
                gaps[i] = int'($urandom_range(0, 3));
                gsum += gaps[i];
            end
            repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom), WIDTH'($urandom), 1'($urandom));
            run_load(data, gaps, 1'($urandom), 1'($urandom), sc, np);
            checks++;
            if (sc != 18 + gsum || np != 1) begin
                failures++;
                $display("FAIL rand_start got cycle=%0d pulses=%0d exp cycle=%0d pulses=1", sc, np, 18 + gsum);
            end
            step(1'b0, 1'b0, '0, 1'b0);
            for (int a = 0; a < DEPTH; a++) begin
                bus.Rd_Addr = AW'(a);
                #1;
                checks++;
                if (bus.Rd_Data !== ref_mem[a] || bus.Rd_Data !== data[a]) begin
                    failures++;
                    $display("FAIL rand_mem addr=%0d got=%h exp=%h", a, bus.Rd_Data, data[a]);
                end
            end
            @(negedge Clk);
            step(1'b0, 1'b0, '0, 1'b1);
        end
    endtask

    initial begin
        bus.Load_Req    = 1'b0;
        bus.Din_Valid   = 1'b0;
        bus.Din         = '0;
        bus.Finder_Done = 1'b0;
        bus.Rd_Addr     = '0;
        @(negedge Clk);
        test_reset();
        test_back_to_back();
        test_gaps();
        test_ini_ignore();
        test_reset_mid();
        test_wait_ignore();
        test_finder();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
